// File: rtl/result_bcd_display_if.sv
// ---------------------------------------------------------------------------
// result_bcd_display_if
// Groups the data-facing signals of the result display block.
//   numi   : binary result from the arithmetic stage
//   carryi : carry/borrow flag from the arithmetic stage
//   bcd    : registered BCD of the last converted value (digit 0 in [3:0])
//   hex0-2 : active-low seven-segment digits, [6:0] = g..a, [7] = dp
//   busy   : conversion in progress
//   done   : one-cycle pulse when the outputs update
// master : the side that produces numi/carryi (arithmetic stage / bench)
// slave  : the display block itself
// ---------------------------------------------------------------------------
interface result_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    numi;
    logic                carryi;
    logic [4*DIGITS-1:0] bcd;
    logic [7:0]          hex0;
    logic [7:0]          hex1;
    logic [7:0]          hex2;
    logic                busy;
    logic                done;

    modport master (
        output numi, carryi,
        input  bcd, hex0, hex1, hex2, busy, done
    );

    modport slave (
        input  numi, carryi,
        output bcd, hex0, hex1, hex2, busy, done
    );
endinterface

// File: rtl/result_bcd_display.sv
// ---------------------------------------------------------------------------
// result_bcd_display
// Watches the arithmetic result and carry flag; whenever either changes it
// runs a sequential double-dabble conversion (one iteration per clock) and
// then updates the BCD register and three seven-segment digits with
// leading-zero blanking. The leftmost digit's dp shows the carry flag.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : result_bcd_display_if.slave (numi, carryi in; bcd, hex0..hex2,
//           busy, done out)
// ---------------------------------------------------------------------------
module result_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    result_bcd_display_if.slave  bus
);
    localparam int SR_W  = 4*DIGITS + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WIDTH:0]      r_cap;          // {carry, num} last captured
    logic [SR_W-1:0]     r_sr;           // {BCD digits, binary}
    logic [CNT_W-1:0]    r_cnt;
    logic [4*DIGITS-1:0] r_bcd;
    logic [7:0]          r_hex0;
    logic [7:0]          r_hex1;
    logic [7:0]          r_hex2;
    logic                r_done;

    logic [WIDTH:0]      w_in;
    logic                w_changed;
    logic                w_cnt_last;
    logic [4*DIGITS-1:0] w_bcd_res;
    logic [3:0]          w_d0;
    logic [3:0]          w_d1;
    logic [3:0]          w_d2;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[WIDTH+4*d +: 4] >= 4'd5)
                t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // Active-low segments g..a for a BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign w_in       = {bus.carryi, bus.numi};
    assign w_changed  = (w_in != r_cap);
    assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));
    // After WIDTH shifts the binary field is empty and the BCD sits on top.
    assign w_bcd_res  = r_sr[SR_W-1:WIDTH];
    assign w_d0       = w_bcd_res[3:0];
    assign w_d1       = w_bcd_res[7:4];
    assign w_d2       = w_bcd_res[11:8];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_changed) w_next_state = CONV;
            CONV:    if (w_cnt_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap  <= '0;
            r_sr   <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_hex0 <= 8'hC0;
            r_hex1 <= 8'hFF;
            r_hex2 <= 8'hFF;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_changed) begin
                        r_cap <= w_in;
                        r_sr  <= {{(4*DIGITS){1'b0}}, bus.numi};
                        r_cnt <= '0;
                    end
                end
                CONV: begin
                    r_sr  <= dabble_step(r_sr);
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_bcd  <= w_bcd_res;
                    r_hex0 <= {1'b1, seg7(w_d0)};
                    r_hex1 <= {1'b1, ((w_d2 == 4'd0) && (w_d1 == 4'd0)) ? 7'h7F : seg7(w_d1)};
                    // dp is the carry indicator, lit even when the digit is blank
                    r_hex2 <= {~r_cap[WIDTH], (w_d2 == 4'd0) ? 7'h7F : seg7(w_d2)};
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd  = r_bcd;
    assign bus.hex0 = r_hex0;
    assign bus.hex1 = r_hex1;
    assign bus.hex2 = r_hex2;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
endmodule

// File: tb/tb_result_bcd_display.sv
module tb_result_bcd_display;
    logic clk = 1'b0;
    logic rst_n;

    result_bcd_display_if #(.WIDTH(8), .DIGITS(3)) u_if ();

    result_bcd_display #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  num;
        logic        carry;
        logic [11:0] bcd;
        logic [7:0]  h0;
        logic [7:0]  h1;
        logic [7:0]  h2;
    } vec_t;

    vec_t vecs[9];

    // Apply a value at a negedge and wait for done; returns negedges waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!u_if.done && cyc < 30);
    endtask

    task automatic chk_outputs(input string tag, input logic [11:0] b,
                               input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2);
        chk({tag, ".bcd"},  32'(u_if.bcd),  32'(b));
        chk({tag, ".hex0"}, 32'(u_if.hex0), 32'(h0));
        chk({tag, ".hex1"}, 32'(u_if.hex1), 32'(h1));
        chk({tag, ".hex2"}, 32'(u_if.hex2), 32'(h2));
    endtask

    initial begin
        int cyc;
        int ndone;
        int extra_done;
        logic [11:0] bcd_seen[2];

        vecs[0] = '{8'd255, 1'b0, 12'h255, 8'h92, 8'h92, 8'hA4};
        vecs[1] = '{8'd7,   1'b0, 12'h007, 8'hF8, 8'hFF, 8'hFF};
        vecs[2] = '{8'd105, 1'b0, 12'h105, 8'h92, 8'hC0, 8'hF9};
        vecs[3] = '{8'd12,  1'b1, 12'h012, 8'hA4, 8'hF9, 8'h7F};
        vecs[4] = '{8'd12,  1'b0, 12'h012, 8'hA4, 8'hF9, 8'hFF};
        vecs[5] = '{8'd0,   1'b0, 12'h000, 8'hC0, 8'hFF, 8'hFF};
        vecs[6] = '{8'd10,  1'b0, 12'h010, 8'hC0, 8'hF9, 8'hFF};
        vecs[7] = '{8'd200, 1'b1, 12'h200, 8'hC0, 8'hC0, 8'h24};
        vecs[8] = '{8'd99,  1'b0, 12'h099, 8'h90, 8'h90, 8'hFF};

        // Reset with zero input: display "0", nothing else happens afterwards.
        rst_n = 1'b0;
        u_if.numi = 8'd0;
        u_if.carryi = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs("reset", 12'h000, 8'hC0, 8'hFF, 8'hFF);
        chk("reset.busy", 32'(u_if.busy), 32'd0);
        chk("reset.done", 32'(u_if.done), 32'd0);
        rst_n = 1'b1;
        extra_done = 0;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.done) extra_done++;
            if (u_if.busy) cyc++;
        end
        chk("idle.done_count", 32'(extra_done), 32'd0);
        chk("idle.busy_count", 32'(cyc), 32'd0);

        // Table-driven conversions.
        for (int v = 0; v < 9; v++) begin
            u_if.numi   = vecs[v].num;
            u_if.carryi = vecs[v].carry;
            @(negedge clk);
            chk($sformatf("v%0d.busy_rise", v), 32'(u_if.busy), 32'd1);
            cyc = 1;
            while (!u_if.done && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("v%0d.latency", v), 32'(cyc), 32'd10);
            chk_outputs($sformatf("v%0d", v), vecs[v].bcd, vecs[v].h0, vecs[v].h1, vecs[v].h2);
            chk($sformatf("v%0d.busy_at_done", v), 32'(u_if.busy), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d.done_width", v), 32'(u_if.done), 32'd0);
        end

        // Input changes mid-conversion: first result is the old value,
        // the new value is picked up afterwards.
        u_if.numi   = 8'd100;
        u_if.carryi = 1'b0;
        ndone = 0;
        bcd_seen[0] = '0;
        bcd_seen[1] = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 3) u_if.numi = 8'd200;
            if (u_if.done) begin
                if (ndone < 2) bcd_seen[ndone] = u_if.bcd;
                if (ndone == 0) chk_outputs("midchg.first", 12'h100, 8'hC0, 8'hC0, 8'hF9);
                ndone++;
            end
        end
        chk("midchg.done_count", 32'(ndone), 32'd2);
        chk("midchg.first_bcd",  32'(bcd_seen[0]), 32'h100);
        chk("midchg.second_bcd", 32'(bcd_seen[1]), 32'h200);
        chk_outputs("midchg.final", 12'h200, 8'hC0, 8'hC0, 8'hA4);

        // Reset in the middle of a conversion, then restart with input held.
        u_if.numi = 8'd42;
        repeat (4) @(negedge clk);
        chk("rstmid.busy_before", 32'(u_if.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs("rstmid", 12'h000, 8'hC0, 8'hFF, 8'hFF);
        chk("rstmid.busy", 32'(u_if.busy), 32'd0);
        chk("rstmid.done", 32'(u_if.done), 32'd0);
        rst_n = 1'b1;
        wait_done(cyc);
        chk("restart.latency", 32'(cyc), 32'd10);
        chk_outputs("restart", 12'h042, 8'hA4, 8'h99, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
        $fatal(1, "timeout");
    end
endmodule
